// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data accesses
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   parameter int TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        owner,
   output logic              err
);

   localparam int SW = $clog2(MAX_WAIT + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic [WW-1:0] wait_cnt;

   // mem_* outputs double as the latched request; requester inputs are ignored after the grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         if_gnt     <= 1'b0;
         if_done    <= 1'b0;
         if_rdata   <= '0;
         d_gnt      <= 1'b0;
         d_done     <= 1'b0;
         d_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         owner      <= 2'b00;
         err        <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (d_req && (!if_req || starve_cnt < MAX_WAIT_C)) begin
                  state      <= BUSY_D;
                  d_gnt      <= 1'b1;
                  owner      <= 2'b10;
                  mem_en     <= 1'b1;
                  mem_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
                  starve_cnt <= if_req ? starve_cnt + 1'b1 : '0;
               end else if (if_req) begin
                  state      <= BUSY_IF;
                  if_gnt     <= 1'b1;
                  owner      <= 2'b01;
                  mem_en     <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end
            BUSY_IF, BUSY_D: begin
               if (mem_ready || wait_cnt == WAIT_LAST) begin
                  state  <= DONE;
                  if_gnt <= 1'b0;
                  d_gnt  <= 1'b0;
                  owner  <= 2'b00;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  err    <= !mem_ready;
                  if (state == BUSY_IF) begin
                     if_done  <= 1'b1;
                     if_rdata <= mem_ready ? mem_rdata : '0;
                  end else begin
                     d_done <= 1'b1;
                     if (!mem_ready)
                        d_rdata <= '0;
                     else if (!mem_we)
                        d_rdata <= mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level check of mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int MAX_WAIT = 4;
   localparam int TIMEOUT  = 15;

   logic        clk = 0, reset = 1;
   logic        if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
   logic        if_gnt, if_done, d_gnt, d_done, mem_en, mem_we, err;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [1:0]  owner;

   int n_checks = 0, n_errors = 0;
   int streak = 0;
   logic [31:0] exp_if_rdata = 0, exp_d_rdata = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One arbitration plus the whole transaction; lat = BUSY cycle index where mem_ready rises
   task automatic run_round(input int lat, input logic [31:0] rd, output logic obs_d);
      logic        win_d, we, to;
      logic [31:0] a, wd;
      int          nbusy;
      obs_d = 1'b0;
      if (!if_req && !d_req) begin
         streak = 0;
         mem_ready = 1'($urandom);
         next_cycle();
         check_val("idle_owner", owner, 2'b00);
         check_val("idle_mem_en", mem_en, 0);
         return;
      end
      if (d_req && if_req) begin
         win_d  = (streak < MAX_WAIT);
         streak = win_d ? streak + 1 : 0;
      end else begin
         win_d  = d_req;
         streak = 0;
      end
      a  = win_d ? d_addr : if_addr;
      wd = d_wdata;
      we = win_d ? d_we : 1'b0;
      to = (lat >= TIMEOUT);
      nbusy = to ? TIMEOUT : lat + 1;
      mem_ready = 1'($urandom);
      next_cycle();
      obs_d = (owner == 2'b10);
      for (int k = 0; k < nbusy; k++) begin
         check_val("busy_owner", owner, win_d ? 2'b10 : 2'b01);
         check_val("busy_if_gnt", if_gnt, !win_d);
         check_val("busy_d_gnt", d_gnt, win_d);
         check_val("busy_mem_en", mem_en, 1);
         check_val("busy_mem_addr", mem_addr, a);
         check_val("busy_mem_we", mem_we, we);
         if (win_d && we) check_val("busy_mem_wdata", mem_wdata, wd);
         check_val("busy_no_done", {if_done, d_done, err}, 3'b000);
         if (k == 1 && win_d) begin
            d_addr = $urandom; d_we = ~d_we; d_wdata = $urandom;
         end
         mem_ready = (k == lat);
         mem_rdata = (k == lat) ? rd : $urandom;
         next_cycle();
      end
      if (win_d) begin
         if (to) exp_d_rdata = 0;
         else if (!we) exp_d_rdata = rd;
      end else begin
         exp_if_rdata = to ? 32'h0 : rd;
      end
      mem_ready = 1'($urandom);
      check_val("done_if", if_done, !win_d);
      check_val("done_d", d_done, win_d);
      check_val("done_err", err, to);
      check_val("done_if_rdata", if_rdata, exp_if_rdata);
      check_val("done_d_rdata", d_rdata, exp_d_rdata);
      check_val("done_bus_idle", {mem_en, mem_we, if_gnt, d_gnt, owner}, 6'b0);
      if (win_d) d_req = 0; else if_req = 0;
      next_cycle();
      check_val("post_done_pulses", {if_done, d_done, err}, 3'b000);
      check_val("post_mem_en", mem_en, 0);
      check_val("post_owner", owner, 2'b00);
      mem_ready = 0;
   endtask

   initial begin
      logic        obs_d;
      logic [9:0]  starve_pat;
      int          r, lat;
      starve_pat = 10'b0111101111;

      // reset with random inputs
      if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom); mem_ready = 1'($urandom);
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; mem_rdata = $urandom;
      next_cycle();
      next_cycle();
      check_val("rst_outputs", {if_gnt, if_done, d_gnt, d_done, mem_en, mem_we, err, owner}, 9'b0);
      check_val("rst_data", {if_rdata, d_rdata}, 64'h0);
      check_val("rst_mem_bus", {mem_addr, mem_wdata}, 64'h0);
      if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
      reset = 0;
      next_cycle();

      // single fetch
      if_req = 1; if_addr = 32'h10;
      run_round(0, 32'h04400008, obs_d);
      check_val("fetch_rdata", if_rdata, 32'h04400008);

      // starvation guard under continuous contention
      for (int i = 0; i < 10; i++) begin
         if (!if_req) begin if_req = 1; if_addr = $urandom; end
         if (!d_req) begin d_req = 1; d_we = 0; d_addr = $urandom; end
         run_round(0, $urandom, obs_d);
         check_val("starve_order", obs_d, starve_pat[i]);
      end
      if_req = 0; d_req = 0;
      run_round(0, 0, obs_d);

      // data write with wait states; address perturbed mid-BUSY
      d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
      run_round(2, $urandom, obs_d);

      // timeout on a read, fetch pending behind it
      d_req = 1; d_we = 0; d_addr = 32'h44; if_req = 1; if_addr = 32'h80;
      run_round(TIMEOUT + 3, $urandom, obs_d);
      check_val("timeout_d_rdata", d_rdata, 32'h0);
      run_round(0, 32'h13572468, obs_d);
      check_val("after_timeout_fetch", obs_d, 1'b0);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         if (!if_req && $urandom_range(0, 1) == 1) begin if_req = 1; if_addr = $urandom; end
         if (!d_req && $urandom_range(0, 1) == 1) begin
            d_req = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
         end
         r = $urandom_range(0, 9);
         lat = (r == 9) ? TIMEOUT + 2 : r % 4;
         run_round(lat, $urandom, obs_d);
      end

      // reset during a data write after data has won 3 contended rounds
      for (int i = 0; i < 12 && streak != 3; i++) begin
         if (!if_req) begin if_req = 1; if_addr = $urandom; end
         if (!d_req) begin d_req = 1; d_we = 1; d_addr = $urandom; d_wdata = $urandom; end
         run_round(0, $urandom, obs_d);
      end
      if (!if_req) begin if_req = 1; if_addr = $urandom; end
      if (!d_req) begin d_req = 1; d_addr = $urandom; d_wdata = $urandom; end
      d_we = 1;
      next_cycle();
      check_val("rstmid_d_gnt", d_gnt, 1);
      check_val("rstmid_mem_we", mem_we, 1);
      mem_ready = 1;
      reset = 1;
      #1;
      check_val("rstmid_async_bus", {mem_en, mem_we, d_gnt, owner}, 5'b0);
      next_cycle();
      check_val("rstmid_no_done", {d_done, if_done, err}, 3'b000);
      mem_ready = 0;
      reset = 0;
      streak = 0; exp_if_rdata = 0; exp_d_rdata = 0;
      d_we = 0;
      run_round(0, $urandom, obs_d);
      check_val("rstmid_data_first", obs_d, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
